pe_blend: RTL
=============

Name: pe_blend

Overview:
- Colour special-effects stage directly downstream of priority evaluation.
- Consumes the per-pixel top and bottom colours, the layer identity and the window effect-enable.
- Applies the BLDCNT mode (alpha blend, brightness up, brightness down) and semi-transparent OBJ blending.
- Streams final 15-bit BGR555 pixels with a column index to the line/frame buffer writer.
- Fixed-latency, non-stalling 3-stage pipeline; blend registers are shadowed at line start.

Parameters:
- LINE_W, 240, visible pixels per line; column counter limit.
- EV_MAX, 16, clamp value for EVA/EVB/EVY coefficients.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line_start  in  1  one-cycle pulse before the first pixel of a line
- in_valid  in  1  pixel present on inputs this cycle
- in_color0  in  15  top-layer colour (BGR555)
- in_color1  in  15  second-layer colour (BGR555)
- in_top  in  6  one-hot top layer {BD,OBJ,BG3,BG2,BG1,BG0}
- in_bot  in  6  one-hot second layer, same encoding
- in_obj_semi  in  1  top layer is a semi-transparent OBJ pixel
- in_fx_en  in  1  window permits special effects for this pixel
- bldcnt  in  16  BLDCNT register
- bldalpha  in  16  BLDALPHA register
- bldy  in  16  BLDY register
- out_valid  out  1  output pixel valid
- out_color  out  15  final BGR555 colour
- out_col  out  8  column index of out_color
- overrun  out  1  sticky flag: more than LINE_W pixels arrived in a line

Behaviour:
- Reset: out_valid=0, out_color=0, out_col=0, overrun=0; pipeline valids cleared; shadow registers=0; column counter=0.
- Reset asserted mid-line discards all in-flight pixels. No output appears until the next in_valid after reset deasserts.
- Shadowing on line_start:
  - Latch bldcnt[13:0], bldalpha[4:0]/[12:8] and bldy[4:0].
  - Clamp each coefficient to EV_MAX (values 17..31 become 16).
  - Clear the column counter and overrun.
- If line_start and in_valid occur together, the pixel uses the newly latched values and gets column 0.
- Register writes during a line have no effect until the next line_start.
- Stage 1, per-pixel decision:
  - T1 = |(in_top & bldcnt[5:0]); T2 = |(in_bot & bldcnt[13:8]); mode = bldcnt[7:6].
  - Alpha is selected when in_fx_en & T2 & (in_obj_semi | (mode==1 & T1)). Semi-transparent OBJ overrides any mode.
  - Otherwise bright-up is selected when in_fx_en & T1 & mode==2.
  - Otherwise bright-down is selected when in_fx_en & T1 & mode==3.
  - Otherwise pass color0 unchanged.
  - Mode 1 with T1 but not T2: pass color0 unchanged.
- Stage 2, per channel (R, G, B are 5 bits each):
  - Alpha: s = c0*EVA + c1*EVB, 10-bit.
  - Bright-up: s = c0*16 + (31-c0)*EVY.
  - Bright-down: s = c0*16 - c0*EVY.
  - Pass: s = c0*16.
- Stage 3: channel = min(31, s>>4), truncating shift.
- out_valid follows in_valid after exactly 3 cycles.
- out_col is the column captured at stage 1. It increments per accepted pixel.
- The column counter saturates at LINE_W-1. Pixel LINE_W+1 and beyond are still output at column LINE_W-1 and set overrun.
- in_valid gaps are allowed: no bubbles are collapsed and latency stays fixed.
- No backpressure. The consumer must accept one pixel per cycle.

Decomposition:
- Package pe_pkg:
  - typedef color_t (15 bits)
  - typedef layer_t (6-bit one-hot)
  - enum blend_op_t {PASS, ALPHA, BRIGHT_UP, BRIGHT_DOWN}
  - BLDCNT field-offset constants, LINE_W
- Sub-module pe_blend_chan: one 5-bit channel of the stage 2/3 arithmetic plus saturation. Instantiate 3 times.

Test Plan:
- Alpha blend: bldcnt=0x0241, EVA=8, EVB=8, top BG0 0x7FFF, bot BG1 0x0000, fx_en=1 → out 0x3DEF, 3 cycles after in_valid.
- Alpha saturation: EVA=16, EVB=16, c0=c1=0x7FFF → out 0x7FFF. Setting EVA=20 is clamped and gives the same result.
- Brightness: mode 2, EVY=16, c0=0x0000 → 0x7FFF. Mode 3, EVY=8, c0=0x7FFF → 0x3DEF. Same stimulus with fx_en=0 → unchanged.
- Semi-transparent OBJ: mode=0, in_obj_semi=1, bot BG2 set in bldcnt[13:8], EVA=16, EVB=0 → out=color0. With bot not a second target → pass.
- Shadowing and columns: change bldalpha mid-line → no effect until line_start. Feed 242 pixels → out_col runs 0..239 then holds 239, overrun=1, cleared by the next line_start.
- Reset mid-stream: assert reset with 3 pixels in flight → out_valid=0 immediately and no stale pixels emerge after release.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the pe_blend colour special-effects stage.
package pe_pkg;

   // Visible pixels per line and coefficient ceiling
   localparam int LINE_W = 240;
   localparam int EV_MAX = 16;

   // BLDCNT field offsets: first-target mask, blend mode, second-target mask
   localparam int CNT_T1_LSB   = 0;
   localparam int CNT_MODE_LSB = 6;
   localparam int CNT_T2_LSB   = 8;

   typedef logic [14:0] color_t;
   typedef logic [5:0]  layer_t;

   typedef enum logic [1:0] {
      PASS        = 2'd0,
      ALPHA       = 2'd1,
      BRIGHT_UP   = 2'd2,
      BRIGHT_DOWN = 2'd3
   } blend_op_t;

   // Coefficients above the ceiling behave as the ceiling itself
   function automatic logic [4:0] clampEv(input logic [4:0] v, input logic [4:0] maxV);
      return (v > maxV) ? maxV : v;
   endfunction

endpackage

// File: rtl/pe_blend_chan.sv
// One 5-bit colour channel: weighted sum (stage 2) then divide-by-16 with saturation (stage 3).
module pe_blend_chan
   import pe_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  blend_op_t  i_op,
   input  logic [4:0] i_c0,
   input  logic [4:0] i_c1,
   input  logic [4:0] i_eva,
   input  logic [4:0] i_evb,
   input  logic [4:0] i_evy,
   output logic [4:0] o_chan
);

   logic [9:0] w_c0;
   logic [9:0] w_c1;
   logic [9:0] w_inv;
   logic [9:0] w_sum;
   logic [9:0] r_sum;
   logic [5:0] w_quot;
   logic       w_unusedLow;

   assign w_c0  = {5'd0, i_c0};
   assign w_c1  = {5'd0, i_c1};
   assign w_inv = {5'd0, 5'd31 - i_c0};

   // Every result is kept in 1/16 units so the final stage is a plain shift
   always_comb begin
      w_sum = w_c0 << 4;
      case (i_op)
         ALPHA:       w_sum = w_c0 * {5'd0, i_eva} + w_c1 * {5'd0, i_evb};
         BRIGHT_UP:   w_sum = (w_c0 << 4) + w_inv * {5'd0, i_evy};
         BRIGHT_DOWN: w_sum = (w_c0 << 4) - w_c0 * {5'd0, i_evy};
         default:     w_sum = w_c0 << 4;
      endcase
   end

   // Stage 2 register holds the unscaled sum
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sum <= '0;
      end else begin
         r_sum <= w_sum;
      end
   end

   // The fractional bits are dropped by the truncating shift
   assign w_quot      = r_sum[9:4];
   assign w_unusedLow = ^r_sum[3:0];

   // Stage 3 register: clamp alpha overflow back to full intensity
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         o_chan <= '0;
      end else begin
         o_chan <= (w_quot > 6'd31) ? 5'd31 : w_quot[4:0];
      end
   end

endmodule

// File: rtl/pe_blend.sv
// Colour special-effects stage: per-pixel blend decision, 3-stage fixed-latency
// pipeline, line-start shadowing of the blend registers and column tracking.
module pe_blend #(
   parameter int LINE_W = pe_pkg::LINE_W,
   parameter int EV_MAX = pe_pkg::EV_MAX
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        line_start,
   input  logic        in_valid,
   input  logic [14:0] in_color0,
   input  logic [14:0] in_color1,
   input  logic [5:0]  in_top,
   input  logic [5:0]  in_bot,
   input  logic        in_obj_semi,
   input  logic        in_fx_en,
   input  logic [15:0] bldcnt,
   input  logic [15:0] bldalpha,
   input  logic [15:0] bldy,
   output logic        out_valid,
   output logic [14:0] out_color,
   output logic [7:0]  out_col,
   output logic        overrun
);

   import pe_pkg::*;

   localparam logic [4:0] EV_LIM   = 5'(EV_MAX);
   localparam logic [7:0] COL_LAST = 8'(LINE_W - 1);

   // Shadowed blend registers and line bookkeeping
   logic [13:0] r_cnt;
   logic [4:0]  r_eva;
   logic [4:0]  r_evb;
   logic [4:0]  r_evy;
   logic [7:0]  r_col;
   logic        r_full;
   logic        r_overrun;

   // Values in force for the pixel arriving this cycle
   logic [13:0] w_cnt;
   logic [4:0]  w_eva;
   logic [4:0]  w_evb;
   logic [4:0]  w_evy;
   logic [7:0]  w_colBase;
   logic        w_fullBase;
   logic        w_t1;
   logic        w_t2;
   logic [1:0]  w_mode;
   blend_op_t   w_op;
   logic        w_unused;

   // Stage 1 pipeline registers
   logic        r_s1Valid;
   blend_op_t   r_s1Op;
   logic [14:0] r_s1C0;
   logic [14:0] r_s1C1;
   logic [4:0]  r_s1Eva;
   logic [4:0]  r_s1Evb;
   logic [4:0]  r_s1Evy;
   logic [7:0]  r_s1Col;

   // Stage 2 sideband
   logic        r_s2Valid;
   logic [7:0]  r_s2Col;

   logic [2:0][4:0] w_chan;

   // A line_start coinciding with a pixel must apply to that pixel, so the
   // freshly latched values bypass the shadow registers for that one cycle
   assign w_cnt      = line_start ? bldcnt[13:0] : r_cnt;
   assign w_eva      = line_start ? clampEv(bldalpha[4:0], EV_LIM)  : r_eva;
   assign w_evb      = line_start ? clampEv(bldalpha[12:8], EV_LIM) : r_evb;
   assign w_evy      = line_start ? clampEv(bldy[4:0], EV_LIM)      : r_evy;
   assign w_colBase  = line_start ? 8'd0 : r_col;
   assign w_fullBase = line_start ? 1'b0 : r_full;

   assign w_t1   = |(in_top & w_cnt[CNT_T1_LSB +: 6]);
   assign w_t2   = |(in_bot & w_cnt[CNT_T2_LSB +: 6]);
   assign w_mode = w_cnt[CNT_MODE_LSB +: 2];

   assign w_unused = ^{bldcnt[15:14], bldalpha[7:5], bldalpha[15:13], bldy[15:5]};

   // Semi-transparent OBJ forces alpha regardless of mode; brightness only needs a first target
   always_comb begin
      w_op = PASS;
      if (in_fx_en && w_t2 && (in_obj_semi || (w_mode == 2'd1 && w_t1))) begin
         w_op = ALPHA;
      end else if (in_fx_en && w_t1 && w_mode == 2'd2) begin
         w_op = BRIGHT_UP;
      end else if (in_fx_en && w_t1 && w_mode == 2'd3) begin
         w_op = BRIGHT_DOWN;
      end
   end

   // Shadow latch at line start; column saturates at the last visible pixel and
   // any pixel arriving after that one marks the line as overrun
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_eva     <= '0;
         r_evb     <= '0;
         r_evy     <= '0;
         r_col     <= '0;
         r_full    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (line_start) begin
            r_cnt     <= bldcnt[13:0];
            r_eva     <= w_eva;
            r_evb     <= w_evb;
            r_evy     <= w_evy;
            r_col     <= 8'd0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
         end
         if (in_valid) begin
            if (w_fullBase) begin
               r_overrun <= 1'b1;
            end else if (w_colBase == COL_LAST) begin
               r_full <= 1'b1;
            end else begin
               r_col <= w_colBase + 8'd1;
            end
         end
      end
   end

   assign overrun = r_overrun;

   // Stage 1 captures the decision and the coefficients so a later line_start
   // cannot alter pixels already in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1Valid <= 1'b0;
         r_s1Op    <= PASS;
         r_s1C0    <= '0;
         r_s1C1    <= '0;
         r_s1Eva   <= '0;
         r_s1Evb   <= '0;
         r_s1Evy   <= '0;
         r_s1Col   <= '0;
      end else begin
         r_s1Valid <= in_valid;
         if (in_valid) begin
            r_s1Op  <= w_op;
            r_s1C0  <= in_color0;
            r_s1C1  <= in_color1;
            r_s1Eva <= w_eva;
            r_s1Evb <= w_evb;
            r_s1Evy <= w_evy;
            r_s1Col <= w_colBase;
         end
      end
   end

   // Valid and column ride alongside the channel arithmetic through stages 2 and 3
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s2Valid <= 1'b0;
         r_s2Col   <= '0;
         out_valid <= 1'b0;
         out_col   <= '0;
      end else begin
         r_s2Valid <= r_s1Valid;
         r_s2Col   <= r_s1Col;
         out_valid <= r_s2Valid;
         out_col   <= r_s2Col;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : gChan
      pe_blend_chan uChan (
         .clock (clock),
         .reset (reset),
         .i_op  (r_s1Op),
         .i_c0  (r_s1C0[5*g +: 5]),
         .i_c1  (r_s1C1[5*g +: 5]),
         .i_eva (r_s1Eva),
         .i_evb (r_s1Evb),
         .i_evy (r_s1Evy),
         .o_chan(w_chan[g])
      );
   end

   assign out_color = w_chan;

endmodule
